imm_gen_pipe: RTL

Parametrised, pipelined RISC-V immediate generator with valid/ready handshakes on both sides. It decodes the instruction format from the opcode, builds the sign-extended immediate at XLEN width, and flags illegal opcodes. Results queue in a small in-order buffer. It sits between instruction fetch/decode and the execute stage of the multi-cycle and pipelined cores, replacing the combinational sign-extend path.

---
 rtl/imm_gen_pipe.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with an in-order result buffer and valid/ready on both sides.
// Optional CSR zimm decode is enabled by defining IMMGEN_ZICSR_EN.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [7:0]       err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] CountFull = CW'(DEPTH);

  localparam logic [2:0] FmtI    = 3'd0;
  localparam logic [2:0] FmtS    = 3'd1;
  localparam logic [2:0] FmtB    = 3'd2;
  localparam logic [2:0] FmtU    = 3'd3;
  localparam logic [2:0] FmtJ    = 3'd4;
  localparam logic [2:0] FmtZ    = 3'd5;
  localparam logic [2:0] FmtNone = 3'd7;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpOp     = 7'b0110011;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("imm_gen_pipe: DEPTH must be a power of two in 2..8");
  end

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [31:0]     imm32;
  logic [2:0]      dec_fmt;
  logic            dec_ill;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    imm32   = '0;
    dec_fmt = FmtNone;
    dec_ill = 1'b1;
    unique case (instr[6:0])
      OpLoad, OpOpImm, OpJalr: begin
        imm32   = {{20{instr[31]}}, instr[31:20]};
        dec_fmt = FmtI;
        dec_ill = 1'b0;
      end
      OpSystem: begin
        imm32   = {{20{instr[31]}}, instr[31:20]};
        dec_fmt = FmtI;
        dec_ill = 1'b0;
`ifdef IMMGEN_ZICSR_EN
        // funct3[2] selects the immediate CSR forms; rs1 field carries zimm.
        if (instr[14]) begin
          imm32   = {27'b0, instr[19:15]};
          dec_fmt = FmtZ;
        end
`endif
      end
      OpStore: begin
        imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        dec_fmt = FmtS;
        dec_ill = 1'b0;
      end
      OpBranch: begin
        imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        dec_fmt = FmtB;
        dec_ill = 1'b0;
      end
      OpLui, OpAuipc: begin
        imm32   = {instr[31:12], 12'b0};
        dec_fmt = FmtU;
        dec_ill = 1'b0;
      end
      OpJal: begin
        imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        dec_fmt = FmtJ;
        dec_ill = 1'b0;
      end
      OpOp: begin
        dec_fmt = FmtNone;
        dec_ill = 1'b0;
      end
      default: begin
        dec_fmt = FmtNone;
        dec_ill = 1'b1;
      end
    endcase
  end

  // All 32-bit forms are already sign-extended to bit 31; widen from there.
  always_comb begin
    dec_imm       = {XLEN{imm32[31]}};
    dec_imm[31:0] = imm32;
  end

  // ---------------------------------------------------------------------------
  // Result buffer
  // ---------------------------------------------------------------------------
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             push, pop;

  logic [XLEN-1:0]  imm_mem [DEPTH];
  logic [2:0]       fmt_mem [DEPTH];
  logic             ill_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  assign in_ready  = (count_q != CountFull) & ~reset;
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push && dec_ill && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Payload storage needs no reset: the count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      imm_mem[wr_ptr_q] <= dec_imm;
      fmt_mem[wr_ptr_q] <= dec_fmt;
      ill_mem[wr_ptr_q] <= dec_ill;
      tag_mem[wr_ptr_q] <= in_tag;
    end
  end

  // Force zeros while empty so reset (which clears the count) blanks the head.
  always_comb begin
    out_imm     = '0;
    out_fmt     = '0;
    out_illegal = 1'b0;
    out_tag     = '0;
    if (out_valid) begin
      out_imm     = imm_mem[rd_ptr_q];
      out_fmt     = fmt_mem[rd_ptr_q];
      out_illegal = ill_mem[rd_ptr_q];
      out_tag     = tag_mem[rd_ptr_q];
    end
  end

  assign err_cnt = err_cnt_q;

endmodule
